aes_byte_loader: RTL and testbench
==================================

AES_BYTE_LOADER -- requirements
Module: aes_byte_loader

Interface
REQ-001 Parameter KEEP_KEY_EN, default 1: when 1, a frame may reuse the previously loaded key; when 0, in_keep_key is ignored.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_byte  input  8  serial byte stream: key bytes, then plaintext bytes, MSB byte first.
REQ-005 in_valid  input  1  in_byte valid.
REQ-006 in_ready  output  1  loader can accept a byte this cycle.
REQ-007 in_mode  input  2  key size: 00=128, 01=192, 10=256, 11=reserved; sampled on frame-first byte only.
REQ-008 in_keep_key  input  1  sampled with in_mode; skip key phase and reuse stored key.
REQ-009 out_block  output  [0:127]  assembled plaintext, byte 0 in bits [0:7].
REQ-010 out_key  output  [0:255]  assembled key, left-aligned, unused tail bits zero.
REQ-011 out_mode  output  2  key size of the presented frame.
REQ-012 out_valid  output  1  block+key+mode stable and valid for the AES encrypt/decrypt stage.
REQ-013 out_ready  input  1  downstream accepts frame.
REQ-014 err_mode  output  1  one-cycle pulse on a rejected reserved-mode byte.

Function
REQ-015 States SHALL be IDLE, KEY, DATA, HOLD; transfer on input occurs when in_valid && in_ready.
REQ-016 in_ready SHALL be 1 in IDLE, KEY, DATA and 0 in HOLD.
REQ-017 In IDLE, a transfer SHALL latch in_mode/in_keep_key and count as the first byte of KEY (or of DATA when keep-key is taken).
REQ-018 Keep-key SHALL be taken only if KEEP_KEY_EN=1, in_keep_key=1, a key is stored (key_loaded=1) and in_mode equals the stored mode; otherwise the key phase runs.
REQ-019 KEY phase SHALL accept exactly 16/24/32 bytes for mode 00/01/10; byte k written to out_key bits [8k:8k+7].
REQ-020 Starting a key phase SHALL zero out_key before byte 0 is written, so bits beyond key length read zero.
REQ-021 DATA phase SHALL accept exactly 16 bytes, byte k to out_block [8k:8k+7]; after byte 15, next state HOLD.
REQ-022 out_valid SHALL assert the cycle after the 16th data byte transfers and stay asserted, with all outputs stable, until out_valid && out_ready.
REQ-023 On out_valid && out_ready, next state IDLE; in_ready rises the following cycle (no same-cycle bypass); out_key, out_mode, key_loaded retained, out_block retained until overwritten.
REQ-024 A frame-first byte with in_mode=11 SHALL be consumed and discarded, state stays IDLE, err_mode pulses one cycle.
REQ-025 in_mode/in_keep_key SHALL be ignored on non-first bytes of a frame.
REQ-026 Byte counter SHALL be 6 bits, cleared on each phase entry; no wrap beyond 31 reachable.
REQ-027 in_valid low mid-phase SHALL stall without state loss; no timeout.

Reset
REQ-028 rst_n low SHALL immediately force state IDLE, counter 0, out_valid 0, err_mode 0, out_block 0, out_key 0, out_mode 00, key_loaded 0.
REQ-029 Reset mid-frame SHALL discard the partial frame; the first byte after deassertion is a frame-first byte.

Structure
REQ-030 Shared package SHALL hold mode encodings, key-byte counts (16/24/32), block byte count 16, state enum.
REQ-031 Single module; no sub-module required; output registers feed the existing combinational AES stages directly.

Verification
REQ-032 Mode 00, bytes 00..0f then 00 11 22 .. ff -> out_key[0:127]=000102..0f, tail zero, out_block=00112233445566778899aabbccddeeff, out_valid one cycle after last byte.
REQ-033 Mode 10 with key 00..1f, same data, out_ready held 0 for 5 cycles -> outputs stable, in_ready=0 throughout, release -> IDLE, in_ready=1 next cycle.
REQ-034 After REQ-032 frame, mode 00 keep_key=1 with 16 data bytes -> key unchanged, exactly 16 bytes consumed; repeat with mode 01 keep_key=1 -> 24-byte key phase runs.
REQ-035 First byte with mode 11 -> byte consumed, err_mode high one cycle, state IDLE; following valid mode-01 frame completes normally.
REQ-036 rst_n pulsed low after 10 key bytes -> all outputs zero immediately; subsequent keep_key=1 frame runs full key phase (key_loaded=0).
REQ-037 Random in_valid gaps on a mode-01 frame -> same outputs as gap-free run.

Source files
------------

// File: rtl/aes_byte_loader_pkg.sv
// Shared encodings for the AES byte loader: key modes, byte counts, FSM states.
package aes_byte_loader_pkg;

    localparam logic [1:0] MODE_128  = 2'b00;
    localparam logic [1:0] MODE_192  = 2'b01;
    localparam logic [1:0] MODE_256  = 2'b10;
    localparam logic [1:0] MODE_RSVD = 2'b11;

    localparam logic [5:0] KEY_BYTES_128 = 6'd16;
    localparam logic [5:0] KEY_BYTES_192 = 6'd24;
    localparam logic [5:0] KEY_BYTES_256 = 6'd32;
    localparam logic [5:0] BLOCK_BYTES   = 6'd16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_KEY  = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    function automatic logic [5:0] key_bytes(input logic [1:0] mode);
        logic [5:0] n;
        case (mode)
            MODE_128: n = KEY_BYTES_128;
            MODE_192: n = KEY_BYTES_192;
            default:  n = KEY_BYTES_256;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/aes_byte_loader.sv
// Serial byte loader: assembles key and plaintext block for the AES stage,
// holding the frame until the downstream handshake completes.
module aes_byte_loader
    import aes_byte_loader_pkg::*;
#(
    parameter bit KEEP_KEY_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_byte,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_mode,
    input  logic         in_keep_key,
    output logic [0:127] out_block,
    output logic [0:255] out_key,
    output logic [1:0]   out_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         err_mode
);

    logic [1:0] state;
    logic [5:0] cnt;
    logic       key_loaded;
    logic       xfer;
    logic       keep_take;
    logic       key_last;
    logic       data_last;

    assign in_ready  = (state != ST_HOLD);
    assign out_valid = (state == ST_HOLD);
    assign xfer      = in_valid && in_ready;

    // Reuse needs a complete stored key of the very same size.
    assign keep_take = KEEP_KEY_EN && in_keep_key && key_loaded
                     && (in_mode == out_mode);
    assign key_last  = (cnt == key_bytes(out_mode) - 6'd1);
    assign data_last = (cnt == BLOCK_BYTES - 6'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            key_loaded <= 1'b0;
            err_mode   <= 1'b0;
            out_block  <= '0;
            out_key    <= '0;
            out_mode   <= MODE_128;
        end else begin
            err_mode <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        if (in_mode == MODE_RSVD) begin
                            err_mode <= 1'b1;
                        end else if (keep_take) begin
                            out_block[0:7] <= in_byte;
                            cnt            <= 6'd1;
                            state          <= ST_DATA;
                        end else begin
                            out_key    <= {in_byte, 248'b0};
                            out_mode   <= in_mode;
                            key_loaded <= 1'b0;
                            cnt        <= 6'd1;
                            state      <= ST_KEY;
                        end
                    end
                end
                ST_KEY: begin
                    if (xfer) begin
                        out_key[{cnt[4:0], 3'b000} +: 8] <= in_byte;
                        if (key_last) begin
                            cnt        <= '0;
                            key_loaded <= 1'b1;
                            state      <= ST_DATA;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        out_block[{cnt[3:0], 3'b000} +: 8] <= in_byte;
                        if (data_last) begin
                            cnt   <= '0;
                            state <= ST_HOLD;
                        end else begin
                            cnt <= cnt + 6'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_byte_loader.sv
// Scoreboard bench for aes_byte_loader: directed frames push expected
// results, a negedge monitor compares every presented frame.
module tb_aes_byte_loader;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [7:0]   in_byte;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic         in_keep_key;
    logic [0:127] out_block;
    logic [0:255] out_key;
    logic [1:0]   out_mode;
    logic         out_valid;
    logic         out_ready;
    logic         err_mode;

    aes_byte_loader #(.KEEP_KEY_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_byte     (in_byte),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mode     (in_mode),
        .in_keep_key (in_keep_key),
        .out_block   (out_block),
        .out_key     (out_key),
        .out_mode    (out_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err_mode    (err_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:127] block;
        logic [0:255] key;
        logic [1:0]   mode;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    logic [0:255] m_key;
    logic [1:0]   m_mode;
    bit           m_loaded;

    task automatic chk(input string name, input logic [255:0] got,
                       input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame got out_valid=1 exp no frame");
            end else begin
                chk("mon_block", 256'(out_block), 256'(q[0].block));
                chk("mon_key", out_key, q[0].key);
                chk("mon_mode", 256'(out_mode), 256'(q[0].mode));
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic [1:0] md,
                             input bit kk);
        int n;
        @(posedge clk);
        #1;
        in_byte     = b;
        in_mode     = md;
        in_keep_key = kk;
        in_valid    = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got in_ready=0 exp 1");
        end
    endtask

    task automatic gap(input bit en);
        int g;
        if (en) begin
            g = $urandom_range(0, 3);
            if (g > 0) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                repeat (g - 1) @(posedge clk);
            end
        end
    endtask

    task automatic frame(input logic [1:0] md, input bit kk,
                         input logic [7:0] kbase, input logic [7:0] dx,
                         input int hold, input bit gaps);
        exp_t e;
        bit   take;
        bit   first;
        int   nk;
        nk   = (md == 2'b00) ? 16 : (md == 2'b01) ? 24 : 32;
        take = kk && m_loaded && (md == m_mode);
        if (!take) begin
            m_key = '0;
            for (int k = 0; k < nk; k++) m_key[8*k +: 8] = 8'(kbase + k);
            m_mode   = md;
            m_loaded = 1'b1;
        end
        e.key  = m_key;
        e.mode = m_mode;
        for (int k = 0; k < 16; k++) e.block[8*k +: 8] = 8'(k * 8'h11) ^ dx;
        q.push_back(e);
        first = 1'b1;
        if (!take) begin
            for (int k = 0; k < nk; k++) begin
                gap(gaps);
                send_byte(8'(kbase + k), first ? md : 2'b11,
                          first ? kk : !kk);
                first = 1'b0;
            end
        end
        for (int k = 0; k < 16; k++) begin
            gap(gaps);
            send_byte(e.block[8*k +: 8], first ? md : 2'b11,
                      first ? kk : !kk);
            first = 1'b0;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("valid_latency", 256'(out_valid), 256'(1));
        chk("hold_in_ready", 256'(in_ready), 256'(0));
        repeat (hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall_valid", 256'(out_valid), 256'(1));
            chk("stall_in_ready", 256'(in_ready), 256'(0));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("release_valid", 256'(out_valid), 256'(0));
        chk("release_in_ready", 256'(in_ready), 256'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        in_byte     = '0;
        in_valid    = 1'b0;
        in_mode     = 2'b00;
        in_keep_key = 1'b0;
        out_ready   = 1'b0;
        m_key       = '0;
        m_mode      = 2'b00;
        m_loaded    = 1'b0;
        #12;
        @(negedge clk);
        chk("rst_valid", 256'(out_valid), 256'(0));
        chk("rst_err", 256'(err_mode), 256'(0));
        chk("rst_block", 256'(out_block), 256'(0));
        chk("rst_key", out_key, 256'(0));
        chk("rst_mode", 256'(out_mode), 256'(0));
        chk("rst_in_ready", 256'(in_ready), 256'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        frame(2'b00, 1'b0, 8'h00, 8'h00, 0, 1'b0);
        frame(2'b00, 1'b1, 8'h40, 8'h5a, 0, 1'b0);
        frame(2'b01, 1'b1, 8'h80, 8'h33, 0, 1'b0);
        frame(2'b10, 1'b0, 8'h00, 8'h00, 5, 1'b0);

        @(posedge clk);
        #1;
        in_byte  = 8'hee;
        in_mode  = 2'b11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("err_pulse", 256'(err_mode), 256'(1));
        chk("err_idle_ready", 256'(in_ready), 256'(1));
        @(negedge clk);
        chk("err_clear", 256'(err_mode), 256'(0));
        chk("err_no_valid", 256'(out_valid), 256'(0));
        frame(2'b01, 1'b0, 8'hc0, 8'h77, 1, 1'b0);

        for (int k = 0; k < 10; k++)
            send_byte(8'(8'h20 + k), k == 0 ? 2'b00 : 2'b11, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_key", out_key, 256'(0));
        chk("mid_rst_block", 256'(out_block), 256'(0));
        chk("mid_rst_mode", 256'(out_mode), 256'(0));
        chk("mid_rst_valid", 256'(out_valid), 256'(0));
        chk("mid_rst_in_ready", 256'(in_ready), 256'(1));
        m_key    = '0;
        m_mode   = 2'b00;
        m_loaded = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame(2'b00, 1'b1, 8'h20, 8'h11, 0, 1'b0);

        frame(2'b01, 1'b0, 8'hc0, 8'h77, 2, 1'b1);

        chk("queue_empty", 256'(q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
